// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and FSM encoding for the Subarashii register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int c_DEF_WIDTH = 16;
   localparam int c_DEF_DEPTH = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } rfState_t;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Pending-write bits with reserve/write/sweep priority and busy
//            outputs. Option macro: ZERO_REG_EN (pend[0] tied low).
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH = c_DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wrEn,
   input  logic [AW-1:0] wrSel,
   input  logic          resvEn,
   input  logic [AW-1:0] resvSel,
   input  logic          sweepEn,
   input  logic [AW-1:0] sweepSel,
   input  logic [AW-1:0] selA,
   input  logic [AW-1:0] selB,
   output logic          busyA,
   output logic          busyB
);

`ifdef ZERO_REG_EN
   localparam bit c_ZERO_REG = 1'b1;
`else
   localparam bit c_ZERO_REG = 1'b0;
`endif

   logic [DEPTH-1:0] w_pend;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_pend
         if (c_ZERO_REG && (i == 0)) begin : g_zero
            assign w_pend[i] = 1'b0;
         end else begin : g_bit
            logic r_bit;
            // Sweep clear beats everything; a new reservation beats a retiring write.
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  r_bit <= 1'b0;
               end else if (sweepEn && (sweepSel == AW'(i))) begin
                  r_bit <= 1'b0;
               end else if (resvEn && (resvSel == AW'(i))) begin
                  r_bit <= 1'b1;
               end else if (wrEn && (wrSel == AW'(i))) begin
                  r_bit <= 1'b0;
               end
            end
            assign w_pend[i] = r_bit;
         end
      end
   endgenerate

   // An in-flight write to the selected register resolves the hazard via bypass.
   assign busyA = w_pend[selA] & ~(wrEn & (wrSel == selA));
   assign busyB = w_pend[selB] & ~(wrEn & (wrSel == selB));

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : 1W/2R register file with write bypass, scoreboard and bulk clear.
//            Option macro: ZERO_REG_EN (register 0 hardwired to zero).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH,
   parameter int DEPTH = c_DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [AW-1:0]    selRd,
   input  logic [WIDTH-1:0] rd,
   input  logic [AW-1:0]    selRa,
   input  logic [AW-1:0]    selRb,
   output logic [WIDTH-1:0] ra,
   output logic [WIDTH-1:0] rb,
   input  logic             resv,
   input  logic [AW-1:0]    resvSel,
   output logic             busyA,
   output logic             busyB,
   input  logic             clr,
   output logic             clrBusy
);

`ifdef ZERO_REG_EN
   localparam bit c_ZERO_REG = 1'b1;
`else
   localparam bit c_ZERO_REG = 1'b0;
`endif

   rfState_t         r_state;
   rfState_t         w_stateNext;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    w_cntNext;
   logic             w_idle;
   logic             w_sweep;
   logic             w_wrEn;
   logic             w_resvEn;
   logic             w_bypA;
   logic             w_bypB;
   logic [WIDTH-1:0] w_regs [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      case (r_state)
         IDLE: begin
            if (clr) begin
               w_stateNext = SWEEP;
               w_cntNext   = '0;
            end
         end
         SWEEP: begin
            w_cntNext = r_cnt + 1'b1;
            if (r_cnt == AW'(DEPTH - 1)) begin
               w_stateNext = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   assign w_idle   = (r_state == IDLE);
   assign w_sweep  = (r_state == SWEEP);
   assign clrBusy  = w_sweep;

   // Index 0 is filtered here so neither storage, bypass nor scoreboard sees it.
   assign w_wrEn   = w_idle & wen  & ~(c_ZERO_REG & (selRd == '0));
   assign w_resvEn = w_idle & resv & ~(c_ZERO_REG & (resvSel == '0));

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_reg
         if (c_ZERO_REG && (i == 0)) begin : g_zero
            assign w_regs[i] = '0;
         end else begin : g_flop
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  r_q <= '0;
               end else if (w_sweep && (r_cnt == AW'(i))) begin
                  r_q <= '0;
               end else if (w_wrEn && (selRd == AW'(i))) begin
                  r_q <= rd;
               end
            end
            assign w_regs[i] = r_q;
         end
      end
   endgenerate

   assign w_bypA = w_wrEn & (selRd == selRa);
   assign w_bypB = w_wrEn & (selRd == selRb);
   assign ra     = w_bypA ? rd : w_regs[selRa];
   assign rb     = w_bypB ? rd : w_regs[selRb];

   rf_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wrEn     (w_wrEn),
      .wrSel    (selRd),
      .resvEn   (w_resvEn),
      .resvSel  (resvSel),
      .sweepEn  (w_sweep),
      .sweepSel (r_cnt),
      .selA     (selRa),
      .selB     (selRb),
      .busyA    (busyA),
      .busyB    (busyB)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed bench for regfile_sb with a behavioural reference model.
//            Option macro: ZERO_REG_EN (adds the hardwired-zero scenario).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

`ifdef ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wen = 1'b0, resv = 1'b0, clr = 1'b0;
   logic [3:0]  selRd = '0, selRa = '0, selRb = '0, resvSel = '0;
   logic [15:0] rd = '0;
   logic [15:0] ra, rb;
   logic        busyA, busyB, clrBusy;

   int total = 0;
   int bad   = 0;
   bit checkOn = 1'b0;

   logic [15:0] mMem [16];
   bit          mPend [16];
   bit          mSweep = 1'b0;
   int          mCnt = 0;

   regfile_sb #(.WIDTH(16), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .wen(wen), .selRd(selRd), .rd(rd),
      .selRa(selRa), .selRb(selRb), .ra(ra), .rb(rb),
      .resv(resv), .resvSel(resvSel), .busyA(busyA), .busyB(busyB),
      .clr(clr), .clrBusy(clrBusy)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 16; i++) begin
         mMem[i]  = '0;
         mPend[i] = 1'b0;
      end
   end

   // Reference model: architectural state advanced once per clock edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            mMem[i]  <= '0;
            mPend[i] <= 1'b0;
         end
         mSweep <= 1'b0;
         mCnt   <= 0;
      end else if (mSweep) begin
         mMem[mCnt]  <= '0;
         mPend[mCnt] <= 1'b0;
         if (mCnt == 15) mSweep <= 1'b0;
         mCnt <= mCnt + 1;
      end else begin
         if (wen && !(ZR && selRd == 0)) begin
            mMem[selRd]  <= rd;
            mPend[selRd] <= 1'b0;
         end
         if (resv && !(ZR && resvSel == 0)) mPend[resvSel] <= 1'b1;
         if (clr) begin
            mSweep <= 1'b1;
            mCnt   <= 0;
         end
      end
   end

   function automatic bit byp(input logic [3:0] sel);
      return !mSweep && wen && (selRd == sel) && !(ZR && sel == 0);
   endfunction

   function automatic logic [15:0] expRd(input logic [3:0] sel);
      if (byp(sel)) return rd;
      if (ZR && sel == 0) return 16'h0000;
      return mMem[sel];
   endfunction

   function automatic logic expBusy(input logic [3:0] sel);
      return mPend[sel] && !byp(sel);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checkOn) begin
         chk("mdl_ra",      32'(ra),      32'(expRd(selRa)));
         chk("mdl_rb",      32'(rb),      32'(expRd(selRb)));
         chk("mdl_busyA",   32'(busyA),   32'(expBusy(selRa)));
         chk("mdl_busyB",   32'(busyB),   32'(expBusy(selRb)));
         chk("mdl_clrBusy", 32'(clrBusy), 32'(mSweep));
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      #2 rst = 1'b0;
      #1 checkOn = 1'b1;
      #9 rst = 1'b1;

      // Reset contents on all selectors
      for (int i = 0; i < 16; i++) begin
         nxt();
         selRa = 4'(i);
         selRb = 4'(15 - i);
         @(negedge clk);
         chk("rst_ra", 32'(ra), 32'h0);
         chk("rst_busy", 32'({busyA, busyB, clrBusy}), 32'h0);
      end

      // Bypass then storage
      nxt(); wen = 1'b1; selRd = 4'd5; rd = 16'hBEEF; selRa = 4'd5;
      @(negedge clk); chk("byp_ra", 32'(ra), 32'hBEEF);
      nxt(); wen = 1'b0;
      @(negedge clk); chk("stor_ra", 32'(ra), 32'hBEEF);

      // Scoreboard
      nxt(); resv = 1'b1; resvSel = 4'd3;
      nxt(); resv = 1'b0; selRa = 4'd3;
      @(negedge clk); chk("resv_busyA", 32'(busyA), 32'h1);
      nxt(); wen = 1'b1; selRd = 4'd3; rd = 16'h1234;
      @(negedge clk);
      chk("wr_busyA", 32'(busyA), 32'h0);
      chk("wr_ra", 32'(ra), 32'h1234);
      nxt(); resv = 1'b1; resvSel = 4'd7; selRd = 4'd7; rd = 16'h7777;
      nxt(); resv = 1'b0; wen = 1'b0; selRb = 4'd7;
      @(negedge clk);
      chk("setwin_busyB", 32'(busyB), 32'h1);
      chk("setwin_rb", 32'(rb), 32'h7777);

      // Fill, then sweep with clr+wen in the same cycle and a dropped mid-sweep write
      for (int i = 0; i < 16; i++) begin
         nxt(); wen = 1'b1; selRd = 4'(i); rd = 16'(16'h1111 * i);
      end
      nxt(); selRd = 4'd9; rd = 16'h9999; clr = 1'b1;
      @(negedge clk); chk("clr_cycle_busy", 32'(clrBusy), 32'h0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         nxt();
         clr = 1'b0; wen = (k == 3); selRd = 4'd2; rd = 16'hABCD;
         @(negedge clk);
         if (!clrBusy) break;
         n++;
      end
      chk("sweep_len", 32'(n), 32'd16);
      for (int i = 0; i < 16; i++) begin
         nxt(); selRa = 4'(i); selRb = 4'(i);
         @(negedge clk);
         chk("swept_ra", 32'(ra), 32'h0);
         chk("swept_busyB", 32'(busyB), 32'h0);
      end
      nxt(); wen = 1'b1; selRd = 4'd4; rd = 16'h4444;
      nxt(); wen = 1'b0; selRa = 4'd4;
      @(negedge clk); chk("post_sweep_wr", 32'(ra), 32'h4444);

      // Reset in the middle of a sweep (cnt = 6)
      nxt(); clr = 1'b1;
      nxt(); clr = 1'b0;
      repeat (6) nxt();
      #2 rst = 1'b0;
      #1 chk("rst_mid_clrBusy", 32'(clrBusy), 32'h0);
      for (int i = 0; i < 16; i++) begin
         nxt(); selRa = 4'(i); selRb = 4'(15 - i);
         @(negedge clk);
         chk("rst_mid_ra", 32'(ra), 32'h0);
         chk("rst_mid_rb", 32'(rb), 32'h0);
      end
      nxt(); rst = 1'b1;
      nxt(); wen = 1'b1; selRd = 4'd6; rd = 16'h0606;
      nxt(); wen = 1'b0; selRa = 4'd6;
      @(negedge clk);
      chk("rst_mid_clrBusy2", 32'(clrBusy), 32'h0);
      chk("post_rst_wr", 32'(ra), 32'h0606);

`ifdef ZERO_REG_EN
      nxt(); wen = 1'b1; selRd = 4'd0; rd = 16'hFFFF; resv = 1'b1; resvSel = 4'd0; selRa = 4'd0;
      @(negedge clk);
      chk("zr_wr_ra", 32'(ra), 32'h0);
      chk("zr_wr_busyA", 32'(busyA), 32'h0);
      nxt(); wen = 1'b0; resv = 1'b0;
      @(negedge clk);
      chk("zr_ra", 32'(ra), 32'h0);
      chk("zr_busyA", 32'(busyA), 32'h0);
`endif

      nxt();
      checkOn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
